light_scan_sequencer: RTL
=========================

LIGHT_SCAN_SEQUENCER -- requirements
Module: light_scan_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE, default 50000, clk cycles per sel step (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  level-sampled command: begin from IDLE/DONE, resume from PAUSE.
REQ-005 SHALL have port stop  input  1  level-sampled command: pause from RUN, abort to IDLE from PAUSE.
REQ-006 SHALL have port step  input  1  advance sel by one while in PAUSE.
REQ-007 SHALL have port loop  input  1  1 = wrap 59->0 and continue; 0 = stop at 59.
REQ-008 SHALL have port sel  output  6  selector driven to the downstream light-line decoders.
REQ-009 SHALL have port busy  output  1  high in RUN and PAUSE.
REQ-010 SHALL have port done  output  1  one-cycle pulse on entry to DONE.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on each 59->0 wrap in RUN.

Function
REQ-012 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-013 sel SHALL always lie in 0..59; values 60..63 SHALL never be driven.
REQ-014 IDLE: start -> RUN next cycle, sel=0, prescaler=0.
REQ-015 RUN: prescaler counts 0..PRESCALE-1; at PRESCALE-1 it generates a tick and returns to 0.
REQ-016 RUN: on tick, sel increments by 1; first sel change occurs exactly PRESCALE cycles after the start-sampling edge.
REQ-017 RUN, tick at sel=59, loop=1: sel->0, wrap=1 for one cycle, remain RUN.
REQ-018 RUN, tick at sel=59, loop=0: sel holds 59, -> DONE, done=1 for one cycle.
REQ-019 RUN: stop -> PAUSE; sel and prescaler hold their values; a tick in the same cycle is discarded.
REQ-020 PAUSE: start (stop low) -> RUN, prescaler resumes from held value.
REQ-021 PAUSE: stop -> IDLE, sel=0, prescaler=0.
REQ-022 PAUSE: step (start, stop low) advances sel by 1 next cycle; 59->0 regardless of loop; no wrap pulse.
REQ-023 step SHALL be ignored outside PAUSE.
REQ-024 Priority when simultaneous: stop > start > step > tick.
REQ-025 DONE: sel holds 59; start -> RUN with sel=0; stop -> IDLE with sel=0.
REQ-026 busy SHALL be a registered decode of state (high exactly in RUN, PAUSE).

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, sel=0, prescaler=0, busy=0, done=0, wrap=0.
REQ-028 Reset asserted mid-RUN SHALL abandon the sequence; after release the block waits in IDLE for start.

Configuration
REQ-029 With macro LIGHT_SCAN_REVERSE_EN defined, SHALL add port dir input 1 (0 up, 1 down) after loop.
REQ-030 With LIGHT_SCAN_REVERSE_EN and dir=1: start loads sel=59, ticks decrement, 0->59 is the wrap/terminal point, step decrements.
REQ-031 dir SHALL be sampled only on the start edge from IDLE/DONE and held for the sequence.
REQ-032 Without LIGHT_SCAN_REVERSE_EN, port dir SHALL not exist and behaviour SHALL be up-count only.

Structure
REQ-033 Package light_pkg SHALL hold SEL_W=6, SEL_MAX=59, and the state typedef.
REQ-034 Prescaler SHALL be sub-module light_prescaler (inputs clk, rst_n, run, clr; output tick).

Verification (PRESCALE=4)
REQ-035 Reset, then start pulse, loop=0 -> sel=1 four cycles after start edge, sel=59 at 240 cycles, done pulse once, state DONE, sel holds 59.
REQ-036 loop=1, run 240+ cycles -> sel 59->0 with single-cycle wrap, busy stays 1, done never asserts.
REQ-037 stop at sel=10 -> sel holds 10 for 20 cycles; three step pulses -> sel=13; start -> sel=14 after remaining prescale count.
REQ-038 start and stop asserted same cycle in RUN -> PAUSE; stop in PAUSE -> IDLE, sel=0, busy=0.
REQ-039 rst_n low for 1 cycle mid-RUN at sel=30 -> sel=0, busy=0 asynchronously; no activity until start.
REQ-040 LIGHT_SCAN_REVERSE_EN, dir=1, loop=0 -> sel=59, 58 after 4 cycles, ..., 0 then done pulse.

Source files
------------

// File: rtl/light_pkg.sv
// Shared types and constants for the light-line scan sequencer.
// Optional reverse scanning is enabled by defining LIGHT_SCAN_REVERSE_EN.
package light_pkg;

  localparam int SEL_W = 6;
  localparam logic [SEL_W-1:0] SEL_MAX = 6'd59;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Next selector position, wrapping within 0..SEL_MAX in either direction.
  function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] s,
                                                input logic down);
    if (down) return (s == '0) ? SEL_MAX : s - 6'd1;
    else      return (s == SEL_MAX) ? '0 : s + 6'd1;
  endfunction

endpackage

// File: rtl/light_prescaler.sv
// Step-rate prescaler: counts 0..PRESCALE-1 while run is high and emits a
// tick on the last count; clr forces the count to zero and wins over run.
module light_prescaler
  import light_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = run && !clr && w_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/light_scan_sequencer.sv
// Light-line scan sequencer: steps a 0..59 selector at the prescaled rate with
// run/pause/step/abort control. Define LIGHT_SCAN_REVERSE_EN to add port dir.
module light_scan_sequencer
  import light_pkg::*;
#(
  parameter int PRESCALE = 50000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             loop,
`ifdef LIGHT_SCAN_REVERSE_EN
  input  logic             dir,
`endif
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic             r_busy;
  logic             r_done;
  logic             r_wrap;

  logic             w_tick;
  logic             w_run;
  logic             w_clr;
  logic             w_launch;
  logic             w_dir;
  logic             w_dir_in;
  logic [SEL_W-1:0] w_load_sel;
  logic [SEL_W-1:0] w_term;

  // A new sequence starts only from IDLE/DONE, and stop always dominates start.
  assign w_launch = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start && !stop;

`ifdef LIGHT_SCAN_REVERSE_EN
  logic r_dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir <= 1'b0;
    end else if (w_launch) begin
      r_dir <= dir;
    end
  end

  assign w_dir    = r_dir;
  assign w_dir_in = dir;
`else
  assign w_dir    = 1'b0;
  assign w_dir_in = 1'b0;
`endif

  assign w_load_sel = w_dir_in ? SEL_MAX : '0;
  assign w_term     = w_dir ? '0 : SEL_MAX;

  // Stop in RUN freezes the prescaler so the pending tick is discarded.
  assign w_run = (r_state == ST_RUN) && !stop;
  assign w_clr = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                 ((r_state == ST_PAUSE) && stop);

  light_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (w_run),
    .clr   (w_clr),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sel   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state <= ST_RUN;
            r_sel   <= w_load_sel;
            r_busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            r_state <= ST_PAUSE;
          end else if (w_tick) begin
            if ((r_sel == w_term) && !loop) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_sel  <= sel_next(r_sel, w_dir);
              r_wrap <= (r_sel == w_term);
            end
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_busy  <= 1'b0;
          end else if (start) begin
            r_state <= ST_RUN;
          end else if (step) begin
            r_sel <= sel_next(r_sel, w_dir);
          end
        end
        ST_DONE: begin
          if (stop) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
          end else if (w_launch) begin
            r_state <= ST_RUN;
            r_sel   <= w_load_sel;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_sel   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign sel  = r_sel;
  assign busy = r_busy;
  assign done = r_done;
  assign wrap = r_wrap;

endmodule
